// File: rtl/scrambler_multi_lane.sv
// Multi-lane self-synchronous scrambler/descrambler for the 64b/66b payload
// path, polynomial x^POLY_HI + x^POLY_MID + 1. Each lane keeps its own
// POLY_HI-bit history of scrambled-domain bits plus a saturating seed counter.
//
// Beat handshake: a beat is accepted when in_enable & in_pop are high on a
// rising clk edge; there is no backpressure. out_pop marks a valid output beat
// (one cycle later with PIPE=1, same cycle with PIPE=0). out_data holds its
// last value while out_pop is low in the registered variant.
module scrambler_multi_lane #(
  parameter int LANES    = 4,
  parameter int WIDTH    = 64,
  parameter int POLY_HI  = 58,
  parameter int POLY_MID = 39,
  parameter int PIPE     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_enable,
  input  logic [1:0]               mode,
  input  logic [LANES-1:0]         lane_clear,
  input  logic                     in_pop,
  input  logic [LANES-1:0]         in_lane_mask,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_pop,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [LANES-1:0]         out_seeded
);

  localparam int CW = $clog2(POLY_HI + WIDTH + 1);
  // Extended history: old state in the low POLY_HI bits (bit 0 oldest),
  // this beat's scrambled-domain bits stacked above it in time order.
  localparam int EW = POLY_HI + WIDTH;

  typedef enum logic [1:0] {
    MODE_BYPASS     = 2'b00,
    MODE_SCRAMBLE   = 2'b01,
    MODE_DESCRAMBLE = 2'b10,
    MODE_RESERVED   = 2'b11
  } mode_t;

  mode_t                mode_q;
  logic [POLY_HI-1:0]   state_q  [LANES];
  logic [CW-1:0]        cnt_q    [LANES];
  logic [POLY_HI-1:0]   state_nx [LANES];
  logic [CW-1:0]        cnt_nx   [LANES];
  logic [LANES*WIDTH-1:0] proc_data;
  logic                 fire;
  logic                 mode_change;
  logic                 processing;

  assign fire        = in_enable & in_pop;
  assign mode_change = (mode != mode_q);
  // Reserved mode 11 falls through to bypass because it is neither active mode.
  assign processing  = (mode_q == MODE_SCRAMBLE) || (mode_q == MODE_DESCRAMBLE);

  // Per-lane bit-serial datapath unrolled across the beat, always using mode_q.
  always_comb begin : lane_datapath
    logic [EW-1:0] ext;
    logic          tap;
    logic          in_bit;
    logic          out_bit;
    logic [CW-1:0] cnt_sum;
    proc_data = in_data;
    for (int k = 0; k < LANES; k++) begin
      ext     = '0;
      ext[POLY_HI-1:0] = state_q[k];
      for (int i = 0; i < WIDTH; i++) begin
        in_bit = in_data[k*WIDTH + i];
        // Taps reach back POLY_MID and POLY_HI bits in the scrambled domain;
        // for the scrambler this includes bits produced earlier in this beat.
        tap = ext[i + POLY_HI - POLY_MID] ^ ext[i];
        if (mode_q == MODE_SCRAMBLE) begin
          ext[POLY_HI + i] = in_bit ^ tap;
          out_bit          = in_bit ^ tap;
        end else begin
          ext[POLY_HI + i] = in_bit;
          out_bit          = in_bit ^ tap;
        end
        if (processing && in_lane_mask[k]) begin
          proc_data[k*WIDTH + i] = out_bit;
        end
      end
      state_nx[k] = ext[EW-1 -: POLY_HI];
      cnt_sum     = cnt_q[k] + CW'(WIDTH);
      cnt_nx[k]   = (cnt_sum >= CW'(POLY_HI)) ? CW'(POLY_HI) : cnt_sum;
    end
  end

  // Mode register and per-lane history/counter; clears win over updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_BYPASS;
      for (int k = 0; k < LANES; k++) begin
        state_q[k] <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      if (mode_change) begin
        mode_q <= mode_t'(mode);
      end
      for (int k = 0; k < LANES; k++) begin
        if (mode_change || lane_clear[k]) begin
          state_q[k] <= '0;
          cnt_q[k]   <= '0;
        end else if (fire && processing && in_lane_mask[k]) begin
          state_q[k] <= state_nx[k];
          cnt_q[k]   <= cnt_nx[k];
        end
      end
    end
  end

  // Seeded status straight from registers; only the descrambler needs seeding.
  always_comb begin
    out_seeded = '0;
    for (int k = 0; k < LANES; k++) begin
      out_seeded[k] = (mode_q != MODE_DESCRAMBLE) || (cnt_q[k] == CW'(POLY_HI));
    end
  end

  generate
    if (PIPE == 1) begin : g_pipe
      // Output register: valid follows accepted beats, data holds when idle.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_pop  <= 1'b0;
          out_data <= '0;
        end else begin
          out_pop <= fire;
          if (fire) begin
            out_data <= proc_data;
          end
        end
      end
    end else begin : g_comb
      assign out_pop  = fire;
      assign out_data = proc_data;
    end
  endgenerate

endmodule

// File: tb/tb_scrambler_multi_lane.sv
// Randomised scoreboard bench for scrambler_multi_lane. A bit-level reference
// model (per-lane history queues of scrambled-domain bits) predicts every
// output beat; a negedge monitor pops and compares.
module tb_scrambler_multi_lane;

  localparam int L  = 4;
  localparam int W  = 64;
  localparam int PH = 58;
  localparam int PM = 39;
  localparam int NRT = 150;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_enable = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [L-1:0]       lane_clear = '0;
  logic               in_pop = 1'b0;
  logic [L-1:0]       in_lane_mask = '0;
  logic [L*W-1:0]     in_data = '0;
  logic               out_pop;
  logic [L*W-1:0]     out_data;
  logic [L-1:0]       out_seeded;

  // Narrow, combinational instance for seeding with WIDTH < POLY_HI.
  logic               r16 = 1'b1;
  logic               en16 = 1'b0;
  logic [1:0]         mode16 = 2'b00;
  logic [0:0]         clr16 = '0;
  logic               pop16 = 1'b0;
  logic [0:0]         mask16 = 1'b1;
  logic [15:0]        din16 = '0;
  logic               op16;
  logic [15:0]        od16;
  logic [0:0]         os16;

  int errors = 0;
  int checks = 0;

  logic [L*W-1:0] exp_q[$];
  bit             hist [L][$];
  int             cnt_m [L];
  logic [1:0]     mq;
  logic           ovr_en = 1'b0;
  logic [L*W-1:0] ovr_val = '0;
  logic [L*W-1:0] last_model_out;
  logic [L*W-1:0] orig [NRT];
  logic [L*W-1:0] scr  [NRT];

  scrambler_multi_lane #(.LANES(L), .WIDTH(W), .POLY_HI(PH), .POLY_MID(PM), .PIPE(1)) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .mode(mode),
    .lane_clear(lane_clear), .in_pop(in_pop), .in_lane_mask(in_lane_mask),
    .in_data(in_data), .out_pop(out_pop), .out_data(out_data), .out_seeded(out_seeded)
  );

  scrambler_multi_lane #(.LANES(1), .WIDTH(16), .POLY_HI(PH), .POLY_MID(PM), .PIPE(0)) dut16 (
    .clk(clk), .reset(r16), .in_enable(en16), .mode(mode16),
    .lane_clear(clr16), .in_pop(pop16), .in_lane_mask(mask16),
    .in_data(din16), .out_pop(op16), .out_data(od16), .out_seeded(os16)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [L*W-1:0] rand_data();
    logic [L*W-1:0] r;
    for (int i = 0; i < L*W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_lane(input int k);
    hist[k].delete();
    repeat (PH) hist[k].push_back(1'b0);
    cnt_m[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < L; k++) clear_lane(k);
    mq = 2'b00;
  endtask

  // Reference: s[n] = d[n]^s[n-PM]^s[n-PH] (scramble), d[n] = s[n]^s[n-PM]^s[n-PH].
  task automatic model_step(input logic en, input logic pop, input logic [1:0] md,
                            input logic [L-1:0] clr, input logic [L-1:0] mask,
                            input logic [L*W-1:0] din, output logic [L*W-1:0] dout);
    bit fire;
    bit chg;
    bit active;
    fire   = en & pop;
    chg    = (md != mq);
    active = (mq == 2'b01) || (mq == 2'b10);
    dout   = din;
    for (int k = 0; k < L; k++) begin
      if (fire && active && mask[k]) begin
        bit h[$];
        h = hist[k];
        for (int i = 0; i < W; i++) begin
          bit d;
          bit t;
          d = din[k*W + i];
          t = h[h.size() - PM] ^ h[h.size() - PH];
          dout[k*W + i] = d ^ t;
          if (mq == 2'b01) h.push_back(d ^ t);
          else h.push_back(d);
        end
        if (!chg && !clr[k]) begin
          while (h.size() > PH) void'(h.pop_front());
          hist[k]  = h;
          cnt_m[k] = (cnt_m[k] + W > PH) ? PH : cnt_m[k] + W;
        end
      end
      if (clr[k] || chg) clear_lane(k);
    end
    if (chg) mq = md;
  endtask

  function automatic logic [L-1:0] exp_seeded();
    logic [L-1:0] s;
    for (int k = 0; k < L; k++) s[k] = (mq != 2'b10) || (cnt_m[k] == PH);
    return s;
  endfunction

  // Driver: apply one cycle of inputs, predict, advance, then check seeded status.
  task automatic cycle(input logic rst, input logic en, input logic [1:0] md,
                       input logic [L-1:0] clr, input logic pop,
                       input logic [L-1:0] mask, input logic [L*W-1:0] din);
    logic [L*W-1:0] dout;
    reset = rst; in_enable = en; mode = md; lane_clear = clr;
    in_pop = pop; in_lane_mask = mask; in_data = din;
    if (rst) begin
      model_reset();
      dout = '0;
    end else begin
      model_step(en, pop, md, clr, mask, din, dout);
      if (en & pop) exp_q.push_back(ovr_en ? ovr_val : dout);
    end
    last_model_out = dout;
    @(posedge clk);
    #1;
    check("seeded", {{(L*W-L){1'b0}}, out_seeded}, {{(L*W-L){1'b0}}, exp_seeded()});
  endtask

  task automatic idle(input logic [1:0] md);
    cycle(1'b0, 1'b1, md, '0, 1'b0, '1, '0);
  endtask

  // Monitor: every presented output beat is compared with the oldest prediction.
  always @(negedge clk) begin
    if (out_pop === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {{(L*W-1){1'b0}}, out_pop}, '0);
      end else begin
        logic [L*W-1:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e);
      end
    end
  end

  initial begin
    logic [L*W-1:0] d;
    logic [1:0]     md;
    logic [63:0]    pat;
    logic [63:0]    imp;
    model_reset();
    // Reset
    cycle(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 2'b00, '0, 1'b0, '0, '0);
    check("reset_pop", {{(L*W-1){1'b0}}, out_pop}, '0);
    check("reset_data", out_data, '0);
    check("reset_seeded", {{(L*W-L){1'b0}}, out_seeded}, {{(L*W-L){1'b0}}, {L{1'b1}}});

    // Bypass beat
    pat = 64'h0123456789ABCDEF;
    cycle(1'b0, 1'b1, 2'b00, '0, 1'b1, '1, {L{pat}});
    check("bypass_pop", {{(L*W-1){1'b0}}, out_pop}, {{(L*W-1){1'b0}}, 1'b1});
    check("bypass_data", out_data, {L{pat}});
    idle(2'b00);

    // Impulse into a zero-state scrambler
    idle(2'b01);
    cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, '1, {{(L*W-1){1'b0}}, 1'b1});
    imp = 64'h0400_0080_0000_0001;
    check("impulse", out_data, {{(L*W-64){1'b0}}, imp});

    // Masked lane passes through unchanged
    d = rand_data();
    cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, 4'b1011, d);
    check("mask_lane2", {{(L*W-W){1'b0}}, out_data[2*W +: W]}, {{(L*W-W){1'b0}}, d[2*W +: W]});
    // Disabled beat produces no output
    cycle(1'b0, 1'b0, 2'b01, '0, 1'b1, '1, rand_data());
    check("enable_off_pop", {{(L*W-1){1'b0}}, out_pop}, '0);
    cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, '1, rand_data());

    // Round trip: scramble from clean state, then descramble the result
    cycle(1'b0, 1'b1, 2'b01, '1, 1'b0, '1, '0);
    for (int j = 0; j < NRT; j++) begin
      orig[j] = rand_data();
      cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, '1, orig[j]);
      scr[j] = last_model_out;
    end
    idle(2'b10);
    check("rt_unseeded", {{(L*W-L){1'b0}}, out_seeded}, '0);
    for (int j = 0; j < NRT; j++) begin
      ovr_en  = (j >= 1);
      ovr_val = orig[j];
      cycle(1'b0, 1'b1, 2'b10, '0, 1'b1, '1, scr[j]);
      if (j == 0)
        check("rt_seeded", {{(L*W-L){1'b0}}, out_seeded}, {{(L*W-L){1'b0}}, {L{1'b1}}});
    end
    ovr_en = 1'b0;

    // Mode switch 01 -> 10 with a beat in the switch cycle
    idle(2'b01);
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, '1, rand_data());
    cycle(1'b0, 1'b1, 2'b10, '0, 1'b1, '1, rand_data());
    check("switch_unseeded", {{(L*W-L){1'b0}}, out_seeded}, '0);

    // Random traffic
    md = 2'b10;
    for (int j = 0; j < 400; j++) begin
      logic [L-1:0] clr;
      if ($urandom_range(0, 29) == 0) md = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 19) == 0) ? L'($urandom_range(1, 15)) : '0;
      cycle(1'b0, ($urandom_range(0, 7) != 0), md, clr, ($urandom_range(0, 3) != 0),
            L'($urandom_range(0, 15)), rand_data());
    end

    // Reset during traffic drops the in-flight beat
    cycle(1'b0, 1'b1, 2'b01, '0, 1'b1, '1, rand_data());
    cycle(1'b1, 1'b1, 2'b01, '0, 1'b1, '1, rand_data());
    check("midreset_pop", {{(L*W-1){1'b0}}, out_pop}, '0);
    check("midreset_data", out_data, '0);
    idle(2'b00);

    // WIDTH=16 descrambler seeding, combinational output
    @(posedge clk); #1;
    r16 = 1'b0; mode16 = 2'b10;
    @(posedge clk); #1;
    check("w16_seed0", {{(L*W-1){1'b0}}, os16}, '0);
    for (int b = 1; b <= 5; b++) begin
      din16 = 16'($urandom); en16 = 1'b1; pop16 = 1'b1;
      #1;
      check("w16_pop", {{(L*W-1){1'b0}}, op16}, {{(L*W-1){1'b0}}, 1'b1});
      if (b == 1) check("w16_first_data", {{(L*W-16){1'b0}}, od16}, {{(L*W-16){1'b0}}, din16});
      @(posedge clk); #1;
      pop16 = 1'b0;
      check("w16_seeded", {{(L*W-1){1'b0}}, os16}, {{(L*W-1){1'b0}}, (b >= 4)});
    end
    en16 = 1'b0; pop16 = 1'b1;
    #1;
    check("w16_enable_off", {{(L*W-1){1'b0}}, op16}, '0);
    pop16 = 1'b0;

    repeat (3) @(posedge clk);
    check("drain", L*W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
